// File: rtl/noc_params.sv
`default_nettype none
// ============================================================================
// Module      : noc_params (package)
// Description : Shared constants and types for the mesh NoC router input port:
//               mesh geometry, VC sizing, flit format, output ports, and the
//               per-VC packet state. Also holds the XY routing function.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_params;

  localparam int MESH_SIZE_X       = 4;
  localparam int MESH_SIZE_Y       = 4;
  localparam int VC_NUM            = 2;
  localparam int VC_SIZE           = $clog2(VC_NUM);
  localparam int DEST_ADDR_SIZE_X  = $clog2(MESH_SIZE_X);
  localparam int DEST_ADDR_SIZE_Y  = $clog2(MESH_SIZE_Y);
  localparam int HEAD_PAYLOAD_SIZE = 16;
  localparam int FLIT_DATA_SIZE    = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + HEAD_PAYLOAD_SIZE;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

  // Per-VC packet state: waiting for a head, waiting for a downstream VC,
  // streaming through the switch.
  typedef enum logic [1:0] {IDLE, VA, SA} vc_state_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;

  typedef union packed {
    head_data_t                head_data;
    logic [FLIT_DATA_SIZE-1:0] bt_pl;
  } flit_data_t;

  typedef struct packed {
    flit_label_t        flit_label;
    logic [VC_SIZE-1:0] vc_id;
    flit_data_t         data;
  } flit_t;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic port_t xy_route(input logic [DEST_ADDR_SIZE_X-1:0] x_dest,
                                     input logic [DEST_ADDR_SIZE_Y-1:0] y_dest,
                                     input int x_cur,
                                     input int y_cur);
    port_t p;
    int    x;
    int    y;
    x = int'(x_dest);
    y = int'(y_dest);
    p = LOCAL;
    if (x < x_cur)      p = WEST;
    else if (x > x_cur) p = EAST;
    else if (y < y_cur) p = NORTH;
    else if (y > y_cur) p = SOUTH;
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vc_buffer.sv
`default_nettype none
// ============================================================================
// Module      : vc_buffer
// Description : One virtual channel of the router input port: flit FIFO,
//               IDLE/VA/SA packet FSM, latched route and downstream VC.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   write_i, data_i   flit addressed to this VC
//   read_i            switch grant for this VC (pops only in SA and non-empty)
//   va_valid_i        VA grant, va_new_vc_i is the granted downstream VC
//   front_flit_o      flit at the FIFO head
//   is_full_o/is_empty_o/is_on_off_o/is_allocatable_o   status
//   va_request_o/sa_request_o                           allocator requests
//   downstream_vc_o/out_port_o                          latched packet info
//   error_o           rejected write this cycle (combinational)
// ============================================================================
module vc_buffer
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 8,
  parameter int X_CURRENT   = MESH_SIZE_X / 2,
  parameter int Y_CURRENT   = MESH_SIZE_Y / 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write_i,
  input  flit_t              data_i,
  input  logic               read_i,
  input  logic               va_valid_i,
  input  logic [VC_SIZE-1:0] va_new_vc_i,
  output flit_t              front_flit_o,
  output logic               is_full_o,
  output logic               is_empty_o,
  output logic               is_on_off_o,
  output logic               is_allocatable_o,
  output logic               va_request_o,
  output logic               sa_request_o,
  output logic [VC_SIZE-1:0] downstream_vc_o,
  output port_t              out_port_o,
  output logic               error_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(BUFFER_SIZE);
  // Two slots of margin cover flits already in flight when the credit drops.
  localparam logic [CNT_W-1:0] ON_OFF_MAX = CNT_W'(BUFFER_SIZE - 2);

  flit_t              mem_q [BUFFER_SIZE];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  vc_state_t          state_q, state_d;
  logic               pkt_open_q, pkt_open_d;
  logic [VC_SIZE-1:0] downstream_vc_q, downstream_vc_d;
  port_t              out_port_q, out_port_d;

  logic w_is_head;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_pop_last;
  logic w_push;

  assign front_flit_o = mem_q[rd_ptr_q];
  assign w_full       = (count_q == FULL_CNT);
  assign w_empty      = (count_q == '0);
  assign w_is_head    = (data_i.flit_label == HEAD) || (data_i.flit_label == HEADTAIL);

  always_comb begin
    w_pop      = read_i && (state_q == SA) && !w_empty;
    w_pop_last = w_pop && ((front_flit_o.flit_label == TAIL) ||
                           (front_flit_o.flit_label == HEADTAIL));
    // Heads open a packet only on an idle VC; body/tail need an open packet.
    w_push     = write_i && !w_full &&
                 (w_is_head ? (state_q == IDLE) : pkt_open_q);
  end

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    state_d         = state_q;
    pkt_open_d      = pkt_open_q;
    downstream_vc_d = downstream_vc_q;
    out_port_d      = out_port_q;

    if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (w_push && !w_pop)      count_d = count_q + CNT_W'(1);
    else if (!w_push && w_pop) count_d = count_q - CNT_W'(1);

    if (w_push) begin
      if (w_is_head) begin
        pkt_open_d = (data_i.flit_label == HEAD);
        out_port_d = xy_route(data_i.data.head_data.x_dest,
                              data_i.data.head_data.y_dest,
                              X_CURRENT, Y_CURRENT);
      end else if (data_i.flit_label == TAIL) begin
        pkt_open_d = 1'b0;
      end
    end

    case (state_q)
      IDLE: if (w_push && w_is_head) state_d = VA;
      VA: begin
        if (va_valid_i) begin
          state_d         = SA;
          downstream_vc_d = va_new_vc_i;
        end
      end
      SA:      if (w_pop_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      state_q         <= IDLE;
      pkt_open_q      <= 1'b0;
      downstream_vc_q <= '0;
      out_port_q      <= LOCAL;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      state_q         <= state_d;
      pkt_open_q      <= pkt_open_d;
      downstream_vc_q <= downstream_vc_d;
      out_port_q      <= out_port_d;
    end
  end

  // Flit storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign is_full_o        = w_full;
  assign is_empty_o       = w_empty;
  assign is_on_off_o      = (count_q <= ON_OFF_MAX);
  assign is_allocatable_o = (state_q == IDLE) && w_empty;
  assign va_request_o     = (state_q == VA);
  assign sa_request_o     = (state_q == SA) && !w_empty;
  assign downstream_vc_o  = downstream_vc_q;
  assign out_port_o       = out_port_q;
  assign error_o          = write_i && !w_push;

endmodule
`default_nettype wire

// File: rtl/noc_input_port.sv
`default_nettype none
// ============================================================================
// Module      : noc_input_port
// Description : Input port of a mesh wormhole router. Demultiplexes incoming
//               flits into VC_NUM virtual-channel buffers and multiplexes the
//               switch-selected VC onto the crossbar, rewriting its VC id to
//               the downstream VC obtained from VC allocation.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                    clock; asynchronous active-low reset
//   data_i, valid_flit_i        incoming flit (data_i.vc_id selects the VC)
//   sa_sel_vc_i, sa_valid_i     switch grant: VC to drive and pop
//   va_new_vc_i, va_valid_i     per-VC downstream VC grant
//   xb_flit_o                   flit to the crossbar (0 when nothing to send)
//   is_on_off_o                 per-VC credit (1 = upstream may send)
//   is_allocatable_vc_o         per-VC idle and empty
//   va_request_o, sa_request_o  per-VC allocator requests
//   sa_downstream_vc_o          per-VC latched downstream VC
//   out_port_o                  per-VC routed output port
//   is_full_o, is_empty_o       per-VC FIFO status
//   error_o                     per-VC rejected flit this cycle
// ============================================================================
module noc_input_port
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 8,
  parameter int X_CURRENT   = MESH_SIZE_X / 2,
  parameter int Y_CURRENT   = MESH_SIZE_Y / 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  flit_t                            data_i,
  input  logic                             valid_flit_i,
  input  logic [VC_SIZE-1:0]               sa_sel_vc_i,
  input  logic                             sa_valid_i,
  input  logic [VC_NUM-1:0][VC_SIZE-1:0]   va_new_vc_i,
  input  logic [VC_NUM-1:0]                va_valid_i,
  output flit_t                            xb_flit_o,
  output logic [VC_NUM-1:0]                is_on_off_o,
  output logic [VC_NUM-1:0]                is_allocatable_vc_o,
  output logic [VC_NUM-1:0]                va_request_o,
  output logic [VC_NUM-1:0]                sa_request_o,
  output logic [VC_NUM-1:0][VC_SIZE-1:0]   sa_downstream_vc_o,
  output port_t [VC_NUM-1:0]               out_port_o,
  output logic [VC_NUM-1:0]                is_full_o,
  output logic [VC_NUM-1:0]                is_empty_o,
  output logic [VC_NUM-1:0]                error_o
);

  flit_t front_flit [VC_NUM];

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    logic w_write;
    logic w_read;

    assign w_write = valid_flit_i && (data_i.vc_id == VC_SIZE'(v));
    assign w_read  = sa_valid_i && (sa_sel_vc_i == VC_SIZE'(v));

    vc_buffer #(
      .BUFFER_SIZE (BUFFER_SIZE),
      .X_CURRENT   (X_CURRENT),
      .Y_CURRENT   (Y_CURRENT)
    ) u_vc_buffer (
      .clk              (clk),
      .rst              (rst),
      .write_i          (w_write),
      .data_i           (data_i),
      .read_i           (w_read),
      .va_valid_i       (va_valid_i[v]),
      .va_new_vc_i      (va_new_vc_i[v]),
      .front_flit_o     (front_flit[v]),
      .is_full_o        (is_full_o[v]),
      .is_empty_o       (is_empty_o[v]),
      .is_on_off_o      (is_on_off_o[v]),
      .is_allocatable_o (is_allocatable_vc_o[v]),
      .va_request_o     (va_request_o[v]),
      .sa_request_o     (sa_request_o[v]),
      .downstream_vc_o  (sa_downstream_vc_o[v]),
      .out_port_o       (out_port_o[v]),
      .error_o          (error_o[v])
    );
  end

  // Only a VC that is streaming and holds a flit has anything meaningful to
  // present; otherwise the crossbar sees zeros.
  always_comb begin
    xb_flit_o = '0;
    if (sa_request_o[sa_sel_vc_i]) begin
      xb_flit_o       = front_flit[sa_sel_vc_i];
      xb_flit_o.vc_id = sa_downstream_vc_o[sa_sel_vc_i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_input_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_input_port
// Description : Directed self-checking bench for noc_input_port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_input_port;
  import noc_params::*;

  logic                           clk;
  logic                           rst;
  flit_t                          data_i;
  logic                           valid_flit_i;
  logic [VC_SIZE-1:0]             sa_sel_vc_i;
  logic                           sa_valid_i;
  logic [VC_NUM-1:0][VC_SIZE-1:0] va_new_vc_i;
  logic [VC_NUM-1:0]              va_valid_i;
  flit_t                          xb_flit_o;
  logic [VC_NUM-1:0]              is_on_off_o;
  logic [VC_NUM-1:0]              is_allocatable_vc_o;
  logic [VC_NUM-1:0]              va_request_o;
  logic [VC_NUM-1:0]              sa_request_o;
  logic [VC_NUM-1:0][VC_SIZE-1:0] sa_downstream_vc_o;
  port_t [VC_NUM-1:0]             out_port_o;
  logic [VC_NUM-1:0]              is_full_o;
  logic [VC_NUM-1:0]              is_empty_o;
  logic [VC_NUM-1:0]              error_o;

  int total = 0;
  int bad   = 0;

  noc_input_port #(.BUFFER_SIZE(8), .X_CURRENT(2), .Y_CURRENT(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .data_i              (data_i),
    .valid_flit_i        (valid_flit_i),
    .sa_sel_vc_i         (sa_sel_vc_i),
    .sa_valid_i          (sa_valid_i),
    .va_new_vc_i         (va_new_vc_i),
    .va_valid_i          (va_valid_i),
    .xb_flit_o           (xb_flit_o),
    .is_on_off_o         (is_on_off_o),
    .is_allocatable_vc_o (is_allocatable_vc_o),
    .va_request_o        (va_request_o),
    .sa_request_o        (sa_request_o),
    .sa_downstream_vc_o  (sa_downstream_vc_o),
    .out_port_o          (out_port_o),
    .is_full_o           (is_full_o),
    .is_empty_o          (is_empty_o),
    .error_o             (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic flit_t mk_head(flit_label_t l, int vc, int x, int y, int pl);
    flit_t f;
    f = '0;
    f.flit_label = l;
    f.vc_id = VC_SIZE'(vc);
    f.data.head_data.x_dest  = DEST_ADDR_SIZE_X'(x);
    f.data.head_data.y_dest  = DEST_ADDR_SIZE_Y'(y);
    f.data.head_data.head_pl = HEAD_PAYLOAD_SIZE'(pl);
    return f;
  endfunction

  function automatic flit_t mk_bt(flit_label_t l, int vc, int pl);
    flit_t f;
    f = '0;
    f.flit_label = l;
    f.vc_id = VC_SIZE'(vc);
    f.data.bt_pl = FLIT_DATA_SIZE'(pl);
    return f;
  endfunction

  task automatic idle_inputs();
    valid_flit_i = 1'b0;
    data_i       = '0;
    sa_valid_i   = 1'b0;
    sa_sel_vc_i  = '0;
    va_valid_i   = '0;
    va_new_vc_i  = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #2;
    total++; if (is_empty_o !== 2'b11) begin bad++; $display("FAIL reset_empty got=%b exp=11", is_empty_o); end
    total++; if (is_full_o !== 2'b00) begin bad++; $display("FAIL reset_full got=%b exp=00", is_full_o); end
    total++; if (is_on_off_o !== 2'b11) begin bad++; $display("FAIL reset_onoff got=%b exp=11", is_on_off_o); end
    total++; if (is_allocatable_vc_o !== 2'b11) begin bad++; $display("FAIL reset_alloc got=%b exp=11", is_allocatable_vc_o); end
    total++; if (va_request_o !== 2'b00 || sa_request_o !== 2'b00) begin bad++; $display("FAIL reset_req got=%b/%b exp=00/00", va_request_o, sa_request_o); end
    total++; if (sa_downstream_vc_o !== '0) begin bad++; $display("FAIL reset_dsvc got=%h exp=0", sa_downstream_vc_o); end
    total++; if (out_port_o[0] !== LOCAL || out_port_o[1] !== LOCAL) begin bad++; $display("FAIL reset_port got=%0d/%0d exp=0/0", out_port_o[0], out_port_o[1]); end
    total++; if (error_o !== 2'b00) begin bad++; $display("FAIL reset_error got=%b exp=00", error_o); end
    total++; if (xb_flit_o !== '0) begin bad++; $display("FAIL reset_xb got=%h exp=0", xb_flit_o); end
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
  endtask

  // H,B,B,T back-to-back, VA at cycle 2 to vc 1, fixed SA reads at cycles 3..6.
  task automatic test_back_to_back();
    flit_t pkt [4];
    flit_t e;
    int    v;
    v = $urandom_range(0, 1);
    pkt[0] = mk_head(HEAD, v, 3, 1, 16'hA001);
    pkt[1] = mk_bt(BODY, v, 20'h11111);
    pkt[2] = mk_bt(BODY, v, 20'h22222);
    pkt[3] = mk_bt(TAIL, v, 20'h33333);
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      if (c < 4) begin valid_flit_i = 1'b1; data_i = pkt[c]; end
      if (c == 2) begin va_valid_i[v] = 1'b1; va_new_vc_i[v] = 1'b1; end
      if (c >= 3 && c <= 6) begin sa_valid_i = 1'b1; sa_sel_vc_i = VC_SIZE'(v); end
      #1;
      if (c == 1) begin
        total++; if (va_request_o[v] !== 1'b1) begin bad++; $display("FAIL b2b_va_req got=%b exp=1", va_request_o[v]); end
        total++; if (out_port_o[v] !== EAST) begin bad++; $display("FAIL b2b_route got=%0d exp=%0d", out_port_o[v], EAST); end
      end
      if (c == 3) begin
        total++; if (sa_request_o[v] !== 1'b1) begin bad++; $display("FAIL b2b_sa_req got=%b exp=1", sa_request_o[v]); end
      end
      if (c >= 3 && c <= 6) begin
        e = pkt[c-3];
        e.vc_id = 1'b1;
        total++; if (xb_flit_o !== e) begin bad++; $display("FAIL b2b_flit%0d got=%h exp=%h", c - 3, xb_flit_o, e); end
      end
      total++; if (error_o !== 2'b00) begin bad++; $display("FAIL b2b_err c=%0d got=%b exp=00", c, error_o); end
      next_cycle();
    end
    idle_inputs();
    total++; if (is_empty_o[v] !== 1'b1 || is_allocatable_vc_o[v] !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b%b exp=11", is_empty_o[v], is_allocatable_vc_o[v]); end
  endtask

  // Same packet with 2 idle cycles between flits; VA granted as soon as
  // requested, SA read whenever requested.
  task automatic test_gapped();
    flit_t pkt [4];
    flit_t exp_q [$];
    flit_t e;
    int    v;
    int    nread;
    v = $urandom_range(0, 1);
    pkt[0] = mk_head(HEAD, v, 0, 2, 16'hB00B);
    pkt[1] = mk_bt(BODY, v, 20'h4A4A4);
    pkt[2] = mk_bt(BODY, v, 20'h5B5B5);
    pkt[3] = mk_bt(TAIL, v, 20'h6C6C6);
    nread = 0;
    for (int c = 0; c < 40 && nread < 4; c++) begin
      idle_inputs();
      if (c % 3 == 0 && c <= 9) begin valid_flit_i = 1'b1; data_i = pkt[c/3]; end
      if (va_request_o[v]) begin va_valid_i[v] = 1'b1; va_new_vc_i[v] = VC_SIZE'(1 - v); end
      if (sa_request_o[v]) begin sa_valid_i = 1'b1; sa_sel_vc_i = VC_SIZE'(v); end
      #1;
      if (sa_valid_i) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL gap_extra got=%h exp=none", xb_flit_o); end
        else begin
          e = exp_q.pop_front();
          e.vc_id = VC_SIZE'(1 - v);
          nread++;
          if (xb_flit_o !== e) begin bad++; $display("FAIL gap_flit%0d got=%h exp=%h", nread - 1, xb_flit_o, e); end
        end
      end
      if (valid_flit_i) begin
        exp_q.push_back(data_i);
        total++; if (error_o !== 2'b00) begin bad++; $display("FAIL gap_err c=%0d got=%b exp=00", c, error_o); end
      end
      next_cycle();
    end
    idle_inputs();
    total++; if (nread !== 4) begin bad++; $display("FAIL gap_count got=%0d exp=4", nread); end
    total++; if (is_allocatable_vc_o[v] !== 1'b1) begin bad++; $display("FAIL gap_idle got=%b exp=1", is_allocatable_vc_o[v]); end
  endtask

  // 16-flit packet longer than the FIFO, read continuously after VA.
  task automatic test_long();
    flit_t exp_q [$];
    flit_t f;
    flit_t e;
    int    nread;
    bit    saw_full;
    nread = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 60 && nread < 16; c++) begin
      idle_inputs();
      if (c < 16) begin
        if (c == 0)       f = mk_head(HEAD, 1, 2, 3, 16'hC000);
        else if (c == 15) f = mk_bt(TAIL, 1, 20'hF0000 + c);
        else              f = mk_bt(BODY, 1, 20'h70000 + c);
        valid_flit_i = 1'b1;
        data_i = f;
      end
      if (va_request_o[1]) begin va_valid_i[1] = 1'b1; va_new_vc_i[1] = 1'b0; end
      if (sa_request_o[1]) begin sa_valid_i = 1'b1; sa_sel_vc_i = 1'b1; end
      #1;
      if (is_full_o[1]) saw_full = 1'b1;
      if (sa_valid_i) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL long_extra got=%h exp=none", xb_flit_o); end
        else begin
          e = exp_q.pop_front();
          e.vc_id = 1'b0;
          nread++;
          if (xb_flit_o !== e) begin bad++; $display("FAIL long_flit%0d got=%h exp=%h", nread - 1, xb_flit_o, e); end
        end
      end
      if (valid_flit_i) exp_q.push_back(data_i);
      next_cycle();
    end
    idle_inputs();
    total++; if (nread !== 16) begin bad++; $display("FAIL long_count got=%0d exp=16", nread); end
    total++; if (saw_full !== 1'b0) begin bad++; $display("FAIL long_full got=%b exp=0", saw_full); end
    total++; if (out_port_o[1] !== SOUTH) begin bad++; $display("FAIL long_route got=%0d exp=%0d", out_port_o[1], SOUTH); end
  endtask

  // Fill VC0 while VA is withheld: credit and full boundaries, overflow drop.
  task automatic test_fill();
    flit_t exp_q [$];
    flit_t e;
    int    nread;
    for (int c = 0; c < 9; c++) begin
      idle_inputs();
      valid_flit_i = 1'b1;
      data_i = (c == 0) ? mk_head(HEAD, 0, 1, 1, 16'hD000) : mk_bt(BODY, 0, 20'hD0000 + c);
      #1;
      if (c == 6) begin
        total++; if (is_on_off_o[0] !== 1'b1) begin bad++; $display("FAIL fill_onoff6 got=%b exp=1", is_on_off_o[0]); end
      end
      if (c == 7) begin
        total++; if (is_on_off_o[0] !== 1'b0 || is_full_o[0] !== 1'b0) begin bad++; $display("FAIL fill_occ7 got=%b%b exp=00", is_on_off_o[0], is_full_o[0]); end
      end
      if (c == 8) begin
        total++; if (is_full_o[0] !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", is_full_o[0]); end
        total++; if (error_o !== 2'b01) begin bad++; $display("FAIL fill_overflow got=%b exp=01", error_o); end
      end else begin
        exp_q.push_back(data_i);
      end
      next_cycle();
    end
    nread = 0;
    for (int c = 0; c < 40 && nread < 9; c++) begin
      idle_inputs();
      if (c == 4) begin valid_flit_i = 1'b1; data_i = mk_bt(TAIL, 0, 20'hDEEEE); end
      if (va_request_o[0]) begin va_valid_i[0] = 1'b1; va_new_vc_i[0] = 1'b1; end
      if (sa_request_o[0]) begin sa_valid_i = 1'b1; sa_sel_vc_i = 1'b0; end
      #1;
      if (sa_valid_i) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL fill_extra got=%h exp=none", xb_flit_o); end
        else begin
          e = exp_q.pop_front();
          e.vc_id = 1'b1;
          nread++;
          if (xb_flit_o !== e) begin bad++; $display("FAIL fill_flit%0d got=%h exp=%h", nread - 1, xb_flit_o, e); end
        end
      end
      if (valid_flit_i) exp_q.push_back(data_i);
      next_cycle();
    end
    idle_inputs();
    total++; if (nread !== 9) begin bad++; $display("FAIL fill_count got=%0d exp=9", nread); end
    total++; if (is_allocatable_vc_o[0] !== 1'b1) begin bad++; $display("FAIL fill_idle got=%b exp=1", is_allocatable_vc_o[0]); end
  endtask

  // H,H,H,B,B,T: extra heads dropped with an error pulse each.
  task automatic test_multi_head();
    flit_t pkt [6];
    flit_t exp_q [$];
    flit_t e;
    logic [VC_NUM-1:0] exp_err;
    int    v;
    int    nread;
    v = $urandom_range(0, 1);
    pkt[0] = mk_head(HEAD, v, 1, 2, 16'hE001);
    pkt[1] = mk_head(HEAD, v, 3, 3, 16'hE002);
    pkt[2] = mk_head(HEAD, v, 0, 0, 16'hE003);
    pkt[3] = mk_bt(BODY, v, 20'hE1111);
    pkt[4] = mk_bt(BODY, v, 20'hE2222);
    pkt[5] = mk_bt(TAIL, v, 20'hE3333);
    nread = 0;
    for (int c = 0; c < 40 && nread < 4; c++) begin
      idle_inputs();
      if (c < 6) begin valid_flit_i = 1'b1; data_i = pkt[c]; end
      if (va_request_o[v]) begin va_valid_i[v] = 1'b1; va_new_vc_i[v] = VC_SIZE'(v); end
      if (sa_request_o[v]) begin sa_valid_i = 1'b1; sa_sel_vc_i = VC_SIZE'(v); end
      #1;
      if (sa_valid_i) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL mh_extra got=%h exp=none", xb_flit_o); end
        else begin
          e = exp_q.pop_front();
          nread++;
          if (xb_flit_o !== e) begin bad++; $display("FAIL mh_flit%0d got=%h exp=%h", nread - 1, xb_flit_o, e); end
        end
      end
      if (c < 6) begin
        exp_err = (c == 1 || c == 2) ? VC_NUM'(1 << v) : '0;
        total++; if (error_o !== exp_err) begin bad++; $display("FAIL mh_err c=%0d got=%b exp=%b", c, error_o, exp_err); end
        if (c != 1 && c != 2) exp_q.push_back(data_i);
      end
      if (c == 1) begin
        total++; if (out_port_o[v] !== WEST) begin bad++; $display("FAIL mh_route got=%0d exp=%0d", out_port_o[v], WEST); end
      end
      next_cycle();
    end
    idle_inputs();
    total++; if (nread !== 4) begin bad++; $display("FAIL mh_count got=%0d exp=4", nread); end
  endtask

  task automatic test_headtail();
    flit_t f;
    flit_t e;
    int    nread;
    f = mk_head(HEADTAIL, 0, 2, 0, 16'h5A5A);
    nread = 0;
    for (int c = 0; c < 20 && nread < 1; c++) begin
      idle_inputs();
      if (c == 0) begin valid_flit_i = 1'b1; data_i = f; end
      if (va_request_o[0]) begin va_valid_i[0] = 1'b1; va_new_vc_i[0] = 1'b1; end
      if (sa_request_o[0]) begin sa_valid_i = 1'b1; sa_sel_vc_i = 1'b0; end
      #1;
      if (c == 1) begin
        total++; if (out_port_o[0] !== NORTH) begin bad++; $display("FAIL ht_route got=%0d exp=%0d", out_port_o[0], NORTH); end
      end
      if (sa_valid_i) begin
        e = f;
        e.vc_id = 1'b1;
        nread++;
        total++; if (xb_flit_o !== e) begin bad++; $display("FAIL ht_flit got=%h exp=%h", xb_flit_o, e); end
      end
      next_cycle();
    end
    idle_inputs();
    total++; if (nread !== 1) begin bad++; $display("FAIL ht_count got=%0d exp=1", nread); end
    total++; if (is_allocatable_vc_o[0] !== 1'b1 || is_empty_o[0] !== 1'b1) begin bad++; $display("FAIL ht_idle got=%b%b exp=11", is_allocatable_vc_o[0], is_empty_o[0]); end
  endtask

  // VC0 4-flit and VC1 5-flit packets interleaved, alternating switch grants.
  task automatic test_interleaved();
    flit_t pkt [9];
    int    wvc [9];
    flit_t q0 [$];
    flit_t q1 [$];
    flit_t e;
    int    n0;
    int    n1;
    int    sel;
    wvc = '{0, 1, 0, 1, 0, 1, 0, 1, 1};
    pkt[0] = mk_head(HEAD, 0, 3, 0, 16'h0A00);
    pkt[1] = mk_head(HEAD, 1, 0, 3, 16'h1A00);
    pkt[2] = mk_bt(BODY, 0, 20'h0B001);
    pkt[3] = mk_bt(BODY, 1, 20'h1B001);
    pkt[4] = mk_bt(BODY, 0, 20'h0B002);
    pkt[5] = mk_bt(BODY, 1, 20'h1B002);
    pkt[6] = mk_bt(TAIL, 0, 20'h0C003);
    pkt[7] = mk_bt(BODY, 1, 20'h1B003);
    pkt[8] = mk_bt(TAIL, 1, 20'h1C004);
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 40 && (n0 < 4 || n1 < 5); c++) begin
      idle_inputs();
      if (c < 9) begin valid_flit_i = 1'b1; data_i = pkt[c]; end
      if (c == 2) begin va_valid_i[0] = 1'b1; va_new_vc_i[0] = 1'b0; end
      if (c == 3) begin va_valid_i[1] = 1'b1; va_new_vc_i[1] = 1'b1; end
      sel = -1;
      if (sa_request_o[c % 2]) sel = c % 2;
      else if (sa_request_o[1 - (c % 2)]) sel = 1 - (c % 2);
      if (sel >= 0) begin sa_valid_i = 1'b1; sa_sel_vc_i = VC_SIZE'(sel); end
      #1;
      if (c == 2) begin
        total++; if (va_request_o !== 2'b11) begin bad++; $display("FAIL il_va_req got=%b exp=11", va_request_o); end
      end
      if (sel == 0) begin
        total++;
        if (q0.size() == 0) begin bad++; $display("FAIL il_extra0 got=%h exp=none", xb_flit_o); end
        else begin
          e = q0.pop_front(); e.vc_id = 1'b0; n0++;
          if (xb_flit_o !== e) begin bad++; $display("FAIL il_vc0_flit%0d got=%h exp=%h", n0 - 1, xb_flit_o, e); end
        end
      end else if (sel == 1) begin
        total++;
        if (q1.size() == 0) begin bad++; $display("FAIL il_extra1 got=%h exp=none", xb_flit_o); end
        else begin
          e = q1.pop_front(); e.vc_id = 1'b1; n1++;
          if (xb_flit_o !== e) begin bad++; $display("FAIL il_vc1_flit%0d got=%h exp=%h", n1 - 1, xb_flit_o, e); end
        end
      end
      if (c < 9) begin
        if (wvc[c] == 0) q0.push_back(data_i); else q1.push_back(data_i);
        total++; if (error_o !== 2'b00) begin bad++; $display("FAIL il_err c=%0d got=%b exp=00", c, error_o); end
      end
      next_cycle();
    end
    idle_inputs();
    total++; if (n0 !== 4 || n1 !== 5) begin bad++; $display("FAIL il_count got=%0d/%0d exp=4/5", n0, n1); end
    total++; if (is_allocatable_vc_o !== 2'b11) begin bad++; $display("FAIL il_idle got=%b exp=11", is_allocatable_vc_o); end
  endtask

  // BODY then TAIL with no HEAD; then a grant to the idle, empty VC.
  task automatic test_orphan_body();
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      if (c == 0) begin valid_flit_i = 1'b1; data_i = mk_bt(BODY, 0, 20'h99999); end
      if (c == 1) begin valid_flit_i = 1'b1; data_i = mk_bt(TAIL, 0, 20'h88888); end
      if (c == 2) begin sa_valid_i = 1'b1; sa_sel_vc_i = 1'b0; end
      #1;
      if (c < 2) begin
        total++; if (error_o !== 2'b01) begin bad++; $display("FAIL orphan_err c=%0d got=%b exp=01", c, error_o); end
      end else begin
        total++; if (xb_flit_o !== '0 || error_o !== 2'b00) begin bad++; $display("FAIL orphan_grant got=%h/%b exp=0/00", xb_flit_o, error_o); end
      end
      next_cycle();
      total++; if (is_empty_o[0] !== 1'b1) begin bad++; $display("FAIL orphan_empty c=%0d got=%b exp=1", c, is_empty_o[0]); end
    end
    idle_inputs();
    total++; if (error_o !== 2'b00) begin bad++; $display("FAIL orphan_err_clear got=%b exp=00", error_o); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_long();
    test_fill();
    test_multi_head();
    test_headtail();
    test_interleaved();
    test_orphan_body();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
